// File: rtl/bitty_control_seq.sv
// Bitty control sequencer: one instruction per handshake, S load, C load, one-hot writeback.
// Optional BITTY_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module bitty_control_seq #(
  parameter int unsigned INST_W = 16,
  parameter int unsigned NREG   = 8,
  localparam int unsigned RW    = $clog2(NREG),
  localparam int unsigned MUX_W = $clog2(NREG + 1),
  localparam int unsigned IMM_W = INST_W - RW - 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic              inst_enable,
  output logic [3:0]        sel,
  output logic              mode,
  output logic [MUX_W-1:0]  mux_sel,
  output logic [IMM_W-1:0]  imm,
  output logic              S_enable,
  output logic              C_enable,
  output logic [NREG-1:0]   reg_enable,
  output logic              done,
`ifdef BITTY_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  output logic              illegal
);

  typedef enum logic [1:0] {StIdle, StLdS, StLdC, StWb} state_e;

  state_e              state_q, state_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [RW-1:0]       rx, ry;
  logic                fmt;
  logic [NREG-1:0]     reg_dec;

  assign rx  = inst_q[INST_W-1 -: RW];
  assign ry  = inst_q[INST_W-1-RW -: RW];
  assign fmt = inst_q[0];

  // Decode only valid register indices; an empty decode marks rx as out of range.
  always_comb begin
    reg_dec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      reg_dec[i] = (rx == RW'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    inst_ready  = 1'b0;
    inst_enable = 1'b0;
    sel         = '0;
    mode        = 1'b0;
    imm         = '0;
    mux_sel     = '0;
    S_enable    = 1'b0;
    C_enable    = 1'b0;
    reg_enable  = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    // Outputs are held low for the whole reset assertion, including inst_ready.
    if (!reset) begin
      sel  = inst_q[5:2];
      mode = inst_q[1];
      imm  = inst_q[INST_W-RW-1:6];
      unique case (state_q)
        StIdle: begin
          inst_ready = 1'b1;
          if (inst_valid) begin
            inst_d  = inst;
            state_d = StLdS;
          end
        end
        StLdS: begin
          mux_sel  = MUX_W'(rx);
          S_enable = 1'b1;
          state_d  = StLdC;
        end
        StLdC: begin
          mux_sel  = fmt ? MUX_W'(NREG) : MUX_W'(ry);
          C_enable = 1'b1;
          state_d  = StWb;
        end
        StWb: begin
          mux_sel    = MUX_W'(rx);
          reg_enable = reg_dec;
          done       = 1'b1;
          illegal    = ~|reg_dec;
          inst_ready = 1'b1;
          if (inst_valid) begin
            inst_d  = inst;
            state_d = StLdS;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
      inst_enable = inst_valid & inst_ready;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
    end
  end

`ifdef BITTY_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else if (done) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_bitty_control_seq.sv
// Directed bench for bitty_control_seq: default build (NREG=8) plus an NREG=6 instance
// sharing the same stimulus for the out-of-range rx case.
module tb_bitty_control_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] inst;
  logic        inst_valid;

  logic        rdy8, en8, s8, c8, done8, ill8, mode8;
  logic [3:0]  sel8, mux8;
  logic [6:0]  imm8;
  logic [7:0]  reg8;

  logic        rdy6, en6, s6, c6, done6, ill6, mode6;
  logic [3:0]  sel6;
  logic [2:0]  mux6;
  logic [6:0]  imm6;
  logic [5:0]  reg6;

`ifdef BITTY_RETIRE_CNT_EN
  logic [31:0] cnt8, cnt6;
  logic [31:0] cnt_before;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bitty_control_seq #(.INST_W(16), .NREG(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (rdy8),
    .inst_enable (en8),
    .sel         (sel8),
    .mode        (mode8),
    .mux_sel     (mux8),
    .imm         (imm8),
    .S_enable    (s8),
    .C_enable    (c8),
    .reg_enable  (reg8),
    .done        (done8),
`ifdef BITTY_RETIRE_CNT_EN
    .retire_cnt  (cnt8),
`endif
    .illegal     (ill8)
  );

  bitty_control_seq #(.INST_W(16), .NREG(6)) u_dut6 (
    .clk         (clk),
    .reset       (reset),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (rdy6),
    .inst_enable (en6),
    .sel         (sel6),
    .mode        (mode6),
    .mux_sel     (mux6),
    .imm         (imm6),
    .S_enable    (s6),
    .C_enable    (c6),
    .reg_enable  (reg6),
    .done        (done6),
`ifdef BITTY_RETIRE_CNT_EN
    .retire_cnt  (cnt6),
`endif
    .illegal     (ill6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] prog [3];
  logic [7:0]  exp_we [3];
  logic [3:0]  exp_rx [3];
  int          bad;

  initial begin
    prog[0] = 16'h2404; exp_rx[0] = 4'd1; exp_we[0] = 8'h02;
    prog[1] = 16'h4E05; exp_rx[1] = 4'd2; exp_we[1] = 8'h04;
    prog[2] = 16'h6004; exp_rx[2] = 4'd3; exp_we[2] = 8'h08;

    reset      = 1'b1;
    inst       = 16'h0;
    inst_valid = 1'b1;
    #1;
    check("rst_ready", {31'd0, rdy8}, 32'd0);
    check("rst_enable", {31'd0, en8}, 32'd0);
    step();
    step();
    check("rst_outs", {24'd0, s8, c8, done8, ill8, reg8 != 8'h0, mux8 != 4'h0, sel8 != 4'h0,
                       mode8}, 32'd0);
`ifdef BITTY_RETIRE_CNT_EN
    check("rst_cnt", cnt8, 32'd0);
`endif

    // 1) idle for 100 cycles
    inst_valid = 1'b0;
    reset      = 1'b0;
    bad        = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!rdy8 || s8 || c8 || done8 || ill8 || reg8 != 8'h0 || en8) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_ready", {31'd0, rdy8}, 32'd1);

    // 2) single register-format issue
    inst       = 16'h2404;
    inst_valid = 1'b1;
    #1;
    check("t2_enable", {31'd0, en8}, 32'd1);
    step();
    inst_valid = 1'b0;
    inst       = 16'hFFFF;
    check("t2_s_en", {31'd0, s8}, 32'd1);
    check("t2_s_mux", {28'd0, mux8}, 32'd1);
    check("t2_lds_ready", {31'd0, rdy8}, 32'd0);
    check("t2_sel", {28'd0, sel8}, 32'd1);
    step();
    check("t2_c_en", {31'd0, c8}, 32'd1);
    check("t2_c_mux", {28'd0, mux8}, 32'd1);
    step();
    check("t2_wb_we", {24'd0, reg8}, 32'h02);
    check("t2_done", {31'd0, done8}, 32'd1);
    check("t2_illegal", {31'd0, ill8}, 32'd0);
    step();
    check("t2_back_idle", {31'd0, rdy8 & ~done8}, 32'd1);

    // 3) immediate format
    inst       = 16'h4E05;
    inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    check("t3_s_mux", {28'd0, mux8}, 32'd2);
    step();
    check("t3_c_mux", {28'd0, mux8}, 32'd8);
    check("t3_imm", {25'd0, imm8}, 32'h38);
    check("t3_mode", {31'd0, mode8}, 32'd0);
    step();
    check("t3_wb_we", {24'd0, reg8}, 32'h04);
    step();

    // 4) inst_valid held high, three back-to-back instructions
    inst       = prog[0];
    inst_valid = 1'b1;
    #1;
    check("t4_accept0", {31'd0, en8}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      if (k < 2) inst = prog[k+1];
      check("t4_lds_ready", {31'd0, rdy8}, 32'd0);
      check("t4_lds_mux", {28'd0, mux8}, {28'd0, exp_rx[k]});
      step();
      check("t4_ldc_ready", {31'd0, rdy8}, 32'd0);
      check("t4_ldc_en", {31'd0, c8}, 32'd1);
      step();
      if (k == 2) inst_valid = 1'b0;
      #1;
      check("t4_done", {31'd0, done8}, 32'd1);
      check("t4_we", {24'd0, reg8}, {24'd0, exp_we[k]});
      check("t4_accept", {31'd0, en8}, (k < 2) ? 32'd1 : 32'd0);
    end
    step();
    check("t4_idle", {31'd0, rdy8 & ~done8}, 32'd1);

    // 5) reset during LD_C
    inst       = 16'h2404;
    inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    step();
    check("t5_in_ldc", {31'd0, c8}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_c", {31'd0, c8}, 32'd0);
    check("t5_rst_ready", {31'd0, rdy8}, 32'd0);
    check("t5_rst_mux", {28'd0, mux8}, 32'd0);
    check("t5_rst_sel", {28'd0, sel8}, 32'd0);
    step();
    reset = 1'b0;
    bad   = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done8 || reg8 != 8'h0 || s8 || c8) bad++;
    end
    check("t5_no_wb", bad, 0);
    check("t5_idle", {31'd0, rdy8}, 32'd1);

    // 6) NREG=6, rx=7 out of range
`ifdef BITTY_RETIRE_CNT_EN
    cnt_before = cnt6;
`endif
    inst       = 16'hE000;
    inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    check("t6_s_mux", {29'd0, mux6}, 32'd7);
    step();
    step();
    check("t6_we", {26'd0, reg6}, 32'd0);
    check("t6_done", {31'd0, done6}, 32'd1);
    check("t6_illegal", {31'd0, ill6}, 32'd1);
    check("t6_nreg8_legal", {24'd0, ill8, reg8[7], 6'd0}, 32'h40);
    step();
    check("t6_done_pulse", {31'd0, done6}, 32'd0);
`ifdef BITTY_RETIRE_CNT_EN
    check("t6_cnt", cnt6, cnt_before + 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
